mem_bus_master: RTL

- Bus initiator that drives the word-addressed data memory's request/ack interface on behalf of the datapath's load/store stage.
- Accepts one byte, halfword or word load/store at a time and checks alignment.
- Sub-word stores are done as read-modify-write, because memory writes are full-word only.
- Load data is lane-extracted and sign- or zero-extended.
- An ack-timeout watchdog converts a hung transaction into an error response.

---
 rtl/mem_bus_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_master.sv
// ============================================================================
// Module   : mem_bus_master
// Brief    : Load/store bus initiator for a word-addressed data memory with
//            alignment checks, read-modify-write sub-word stores, load lane
//            extraction/extension and an ack-timeout watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_bus_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_rd   = 2'd1;
  localparam logic [1:0] c_wr   = 2'd2;
  localparam logic [1:0] c_resp = 2'd3;

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last =
    c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]         r_state;
  logic [31:0]        r_addr;
  logic [1:0]         r_size;
  logic               r_we;
  logic               r_unsigned;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_bad_req;
  logic               w_timeout;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic [31:0]        w_merged;

  always_comb begin
    w_bad_req = 1'b0;
    case (req_size_i)
      2'b00:   w_bad_req = 1'b0;
      2'b01:   w_bad_req = req_addr_i[0];
      2'b10:   w_bad_req = (req_addr_i[1:0] != 2'b00);
      default: w_bad_req = 1'b1;
    endcase
  end

  // A zero timeout parameter disables the watchdog; the counter then just wraps.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_last);

  assign w_byte = mem_data_i[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = mem_data_i[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = mem_data_i;
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = mem_data_i;
    endcase
  end

  always_comb begin
    w_merged = mem_data_i;
    if (r_size == 2'b00) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_idle;
      r_addr     <= '0;
      r_size     <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (req_valid_i) begin
            r_addr     <= req_addr_i;
            r_size     <= req_size_i;
            r_we       <= req_we_i;
            r_unsigned <= req_unsigned_i;
            r_wdata    <= req_wdata_i;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            if (w_bad_req) begin
              r_err   <= 1'b1;
              r_state <= c_resp;
            end else if (req_we_i && (req_size_i == 2'b10)) begin
              r_state <= c_wr;
            end else begin
              r_state <= c_rd;
            end
          end
        end
        c_rd: begin
          // Ack wins over the watchdog on the last permitted cycle.
          if (mem_ack_i) begin
            if (r_we) begin
              r_wdata <= w_merged;
              r_cnt   <= '0;
              r_state <= c_wr;
            end else begin
              r_rdata <= w_load;
              r_state <= c_resp;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= c_resp;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_wr: begin
          if (mem_ack_i) begin
            r_state <= c_resp;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= c_resp;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign req_ready_o  = (r_state == c_idle);
  assign resp_valid_o = (r_state == c_resp);
  assign resp_rdata_o = resp_valid_o ? r_rdata : 32'd0;
  assign resp_err_o   = resp_valid_o & r_err;
  assign mem_rd_en_o  = (r_state == c_rd);
  assign mem_wr_en_o  = (r_state == c_wr);
  assign mem_addr_o   = {r_addr[31:2], 2'b00};
  assign mem_data_o   = mem_wr_en_o ? r_wdata : 32'd0;

endmodule

`default_nettype wire
